instr_fetch_decode: RTL and testbench
=====================================

// Module: instr_fetch_decode
// PURPOSE
//  Front end of the 8-bit CPU. Reads instruction bytes from synchronous program memory starting at ip.
//  Turns each opcode byte into a lib_cpu::OPECODE, plus an 8-bit immediate where the opcode needs one.
//  Hands each decoded instruction to the execute stage over a valid/ready handshake.
//  Accepts jump redirects (JMP_IMM, taken JNC_IMM) back from execute and flushes in-flight fetches.
// PARAMETERS
//  ADDR_W    8     program address width; ip wraps modulo 2**ADDR_W
//  RESET_PC  0     ip loaded at reset
// PORTS
//  clk             in   1       single clock, all state on rising edge
//  rst_n           in   1       asynchronous active-low reset
//  run             in   1       1 = fetch allowed; 0 = halt before the next fetch issue
//  mem_en          out  1       program memory read strobe
//  mem_addr        out  ADDR_W  read address
//  mem_rdata       in   8       read data, valid exactly 1 cycle after mem_en
//  redirect_valid  in   1       execute requests restart at redirect_addr
//  redirect_addr   in   ADDR_W  jump target
//  dec_valid       out  1       decoded instruction present
//  dec_ready       in   1       execute accepts when dec_valid&&dec_ready
//  dec_op          out  OPECODE decoded opcode
//  dec_imm         out  8       immediate; 0 for 1-byte instructions
//  dec_pc          out  ADDR_W  address of the opcode byte
//  illegal_seen    out  1       sticky: an INVALID opcode was ever presented; cleared only by reset
// BEHAVIOUR
//  Encoding:
//   - opcode byte value = OPECODE enum index 0..11; any value >=12 decodes to INVALID.
//   - 2-byte instructions (imm in the next byte): ADD_A_IMM, ADD_B_IMM, MOV_A_IMM, MOV_B_IMM, JMP_IMM, JNC_IMM, OUT_IMM.
//   - All other opcodes, and INVALID, are 1 byte long.
//  Reset:
//   - pc=RESET_PC, state=FETCH.
//   - Outputs: mem_en=0, mem_addr=RESET_PC, dec_valid=0, dec_op=INVALID, dec_imm=0, dec_pc=RESET_PC, illegal_seen=0.
//  FSM (registered; mem_en/mem_addr are combinational from state):
//   - FETCH: if run, mem_en=1, mem_addr=pc, go OPC; else stay with mem_en=0.
//   - OPC: decode mem_rdata into op_q.
//     - 2-byte opcode: mem_en=1, mem_addr=pc+1, go IMM.
//     - Otherwise: load outputs with imm=0, go OUT.
//   - IMM: load outputs with imm=mem_rdata, go OUT.
//   - OUT: dec_valid=1; outputs stay stable until the handshake.
//     - On handshake: pc<=pc+len.
//     - If run: mem_en=1, mem_addr=pc+len in the same cycle, go OPC. Else go FETCH.
//  Latency:
//   - From the FETCH issue cycle t, dec_valid rises at t+2 (1-byte) or t+3 (2-byte).
//   - Back-to-back: handshake cycle h gives the next dec_valid at h+2 or h+3.
//  Redirect:
//   - Highest priority in every state: pc<=redirect_addr, state<=FETCH, dec_valid<=0 next cycle.
//   - A read already in flight is discarded; mem_en=0 in the redirect cycle.
//   - A handshake in the same cycle still counts as consumed, but pc takes redirect_addr, not pc+len.
//  Arithmetic: pc+1 and pc+len wrap modulo 2**ADDR_W, so a 2-byte instruction at the top address reads its imm from 0.
//  run deasserted mid-instruction: the current instruction completes through OUT; the halt applies at the next fetch issue.
//  illegal_seen sets on the cycle dec_valid first rises with dec_op==INVALID.
//  Reset mid-operation: everything returns asynchronously to reset values; no partial instruction is presented.
// STRUCTURE
//  lib_cpu package gains:
//   - localparam OPC_COUNT=12
//   - function opc_decode(logic[7:0]) -> OPECODE (>=OPC_COUNT -> INVALID)
//   - function opc_has_imm(OPECODE) -> logic
//   - FETCH_STATE enum {FETCH, OPC, IMM, OUT}
//  No sub-module: decoding is done by the package functions; the FSM and output registers are local.
// TESTING
//  - Reset, RESET_PC=0, mem[0]=MOV_A_B(4), ready=1 -> mem_en@c0 addr0; dec_valid@c2 op=MOV_A_B imm=0 pc=0.
//  - mem[0..2]={MOV_A_IMM(2),0x5A,OUT_B(10)}, ready=1 -> (MOV_A_IMM,0x5A,pc0) then (OUT_B,0,pc2); mem_addr sequence 0,1,2.
//  - dec_ready=0 for 5 cycles while dec_valid -> outputs stable, mem_en=0; release -> next fetch issued in the handshake cycle.
//  - JMP_IMM at 0x10 accepted, redirect_valid with addr 0x40 in OPC of the following instr -> that instr never presented; next dec_pc=0x40.
//  - ADD_B_IMM(1) at 0xFF, mem[0x00]=0x07 -> imm read from addr 0x00, imm=0x07; next fetch addr 0x01.
//  - Opcode byte 0xC8 -> dec_op=INVALID, imm=0, pc advances by 1, illegal_seen=1 until rst_n low.

Source files
------------

// File: rtl/instr_fetch_decode_pkg.sv
// Opcode encoding, fetch FSM states and decode helpers for the 8-bit CPU front end.
// Pure definitions, no timing of its own.
// Decode is total: every byte maps to an opcode, with INVALID for unused values.
package lib_cpu;

  // Opcode byte value equals the enum index; INVALID covers every byte >= OPC_COUNT.
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'd0,
    ADD_B_IMM = 4'd1,
    MOV_A_IMM = 4'd2,
    MOV_B_IMM = 4'd3,
    MOV_A_B   = 4'd4,
    MOV_B_A   = 4'd5,
    JMP_IMM   = 4'd6,
    JNC_IMM   = 4'd7,
    IN_A      = 4'd8,
    IN_B      = 4'd9,
    OUT_B     = 4'd10,
    OUT_IMM   = 4'd11,
    INVALID   = 4'd12
  } OPECODE;

  localparam int OPC_COUNT = 12;

  typedef enum logic [1:0] {FETCH, OPC, IMM, OUT} FETCH_STATE;

  function automatic OPECODE opc_decode(input logic [7:0] b);
    OPECODE op;
    op = INVALID;
    if (b < 8'(OPC_COUNT)) op = OPECODE'(b[3:0]);
    return op;
  endfunction

  // Opcodes whose immediate lives in the byte after the opcode.
  function automatic logic opc_has_imm(input OPECODE op);
    logic r;
    r = 1'b0;
    case (op)
      ADD_A_IMM, ADD_B_IMM, MOV_A_IMM, MOV_B_IMM,
      JMP_IMM, JNC_IMM, OUT_IMM: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Program-memory read port, redirect input and decoded-instruction handshake.
// No logic; timing is set by the fetch unit.
// dec_valid/dec_ready handshake; redirect is a single-cycle strobe.
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 8
);
  import lib_cpu::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              dec_valid;
  logic              dec_ready;
  OPECODE            dec_op;
  logic [7:0]        dec_imm;
  logic [ADDR_W-1:0] dec_pc;

  // Fetch unit side.
  modport master (
    output mem_en, mem_addr, dec_valid, dec_op, dec_imm, dec_pc,
    input  mem_rdata, redirect_valid, redirect_addr, dec_ready
  );

  // Memory / execute side.
  modport slave (
    input  mem_en, mem_addr, dec_valid, dec_op, dec_imm, dec_pc,
    output mem_rdata, redirect_valid, redirect_addr, dec_ready
  );

endinterface

// File: rtl/instr_fetch_decode.sv
// Fetches opcode (+ optional immediate) bytes, decodes them and presents them to execute.
// dec_valid 2 cycles after fetch issue for 1-byte, 3 cycles for 2-byte instructions.
// Holds outputs stable and issues no reads while dec_valid && !dec_ready; redirect flushes.
module instr_fetch_decode
  import lib_cpu::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  instr_fetch_decode_if.master   bus,
  output logic                   illegal_seen
);

  FETCH_STATE        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  OPECODE            op_q, op_d;
  OPECODE            dec_op_q, dec_op_d;
  logic [7:0]        dec_imm_q, dec_imm_d;
  logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
  logic              illegal_q, illegal_d;
  logic              mem_en_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [ADDR_W-1:0] len;
  OPECODE            rd_op;

  assign len   = opc_has_imm(dec_op_q) ? ADDR_W'(2) : ADDR_W'(1);
  assign rd_op = opc_decode(bus.mem_rdata);

  // Next-state, read strobe and output-register loads; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    dec_op_d   = dec_op_q;
    dec_imm_d  = dec_imm_q;
    dec_pc_d   = dec_pc_q;
    mem_en_c   = 1'b0;
    mem_addr_c = pc_q;
    unique case (state_q)
      FETCH: begin
        if (run) begin
          mem_en_c = 1'b1;
          state_d  = OPC;
        end
      end
      OPC: begin
        op_d = rd_op;
        if (opc_has_imm(rd_op)) begin
          mem_en_c   = 1'b1;
          mem_addr_c = pc_q + ADDR_W'(1);
          state_d    = IMM;
        end else begin
          dec_op_d  = rd_op;
          dec_imm_d = 8'h00;
          dec_pc_d  = pc_q;
          state_d   = OUT;
        end
      end
      IMM: begin
        dec_op_d  = op_q;
        dec_imm_d = bus.mem_rdata;
        dec_pc_d  = pc_q;
        state_d   = OUT;
      end
      OUT: begin
        if (bus.dec_ready) begin
          pc_d = pc_q + len;
          if (run) begin
            mem_en_c   = 1'b1;
            mem_addr_c = pc_q + len;
            state_d    = OPC;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = FETCH;
    endcase
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_addr;
      state_d    = FETCH;
      mem_en_c   = 1'b0;
      mem_addr_c = pc_q;
    end
  end

  // Sticky flag raised together with the first presentation of an INVALID opcode.
  always_comb begin
    illegal_d = illegal_q;
    if (state_d == OUT && state_q != OUT && dec_op_d == INVALID) illegal_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      op_q      <= INVALID;
      dec_op_q  <= INVALID;
      dec_imm_q <= 8'h00;
      dec_pc_q  <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      dec_op_q  <= dec_op_d;
      dec_imm_q <= dec_imm_d;
      dec_pc_q  <= dec_pc_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.dec_valid = (state_q == OUT);
  assign bus.dec_op    = dec_op_q;
  assign bus.dec_imm   = dec_imm_q;
  assign bus.dec_pc    = dec_pc_q;
  assign illegal_seen  = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed scenarios plus a random run
// against a program-walking reference model.
// Bench acts as program memory (1-cycle read) and as the execute stage.
module tb_instr_fetch_decode;
  import lib_cpu::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic illegal_seen;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_fetch_decode_if #(.ADDR_W(AW)) bus ();

  instr_fetch_decode #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .bus          (bus),
    .illegal_seen (illegal_seen)
  );

  logic [7:0] mem [256];

  // Synchronous program memory: data one cycle after the strobe.
  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the encoding table.
  function automatic int m_op(input logic [7:0] b);
    return (b < 8'd12) ? int'(b) : 12;
  endfunction

  function automatic logic [7:0] m_len(input logic [7:0] b);
    int o;
    o = m_op(b);
    return (o == 0 || o == 1 || o == 2 || o == 3 || o == 6 || o == 7 || o == 11) ? 8'd2 : 8'd1;
  endfunction

  // Advance to 2 time units after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.dec_valid && n < 20) begin
      nxt();
      n++;
    end
    chk("wait_valid", 32'(bus.dec_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    bus.redirect_valid = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    run   = 1'b1;
    #1;
  endtask

  task automatic redirect(input logic [7:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = a;
    #1;
    chk("redir_mem_en", 32'(bus.mem_en), 32'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    int first_v;
    int second_v;
    logic [7:0] addrs[$];
    logic [7:0] model_pc;
    logic [7:0] nb;
    logic       model_ill;
    logic       redir;
    int         nhs;

    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.dec_ready      = 1'b1;
    foreach (mem[i]) mem[i] = 8'h00;

    // Reset values and first-instruction latency.
    mem[0] = 8'd4;
    nxt();
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_op", 32'(bus.dec_op), 32'd12);
    chk("rst_imm", 32'(bus.dec_imm), 32'd0);
    chk("rst_pc", 32'(bus.dec_pc), 32'd0);
    chk("rst_illegal", 32'(illegal_seen), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    #1;
    chk("t1_c0_mem_en", 32'(bus.mem_en), 32'd1);
    chk("t1_c0_addr", 32'(bus.mem_addr), 32'd0);
    nxt();
    chk("t1_c1_valid", 32'(bus.dec_valid), 32'd0);
    nxt();
    chk("t1_c2_valid", 32'(bus.dec_valid), 32'd1);
    chk("t1_op", 32'(bus.dec_op), 32'd4);
    chk("t1_imm", 32'(bus.dec_imm), 32'd0);
    chk("t1_pc", 32'(bus.dec_pc), 32'd0);

    // Two-byte then one-byte instruction, address sequence and back-to-back latency.
    mem[0] = 8'd2; mem[1] = 8'h5A; mem[2] = 8'd10; mem[3] = 8'd4;
    do_reset();
    first_v = -1; second_v = -1;
    for (int c = 0; c < 8; c++) begin
      if (bus.mem_en) addrs.push_back(bus.mem_addr);
      if (bus.dec_valid && first_v < 0) begin
        first_v = c;
        chk("t2_op0", 32'(bus.dec_op), 32'd2);
        chk("t2_imm0", 32'(bus.dec_imm), 32'h5A);
        chk("t2_pc0", 32'(bus.dec_pc), 32'd0);
      end else if (bus.dec_valid && first_v >= 0 && second_v < 0) begin
        second_v = c;
        chk("t2_op1", 32'(bus.dec_op), 32'd10);
        chk("t2_imm1", 32'(bus.dec_imm), 32'd0);
        chk("t2_pc1", 32'(bus.dec_pc), 32'd2);
      end
      nxt();
    end
    chk("t2_lat_first", 32'(first_v), 32'd3);
    chk("t2_lat_second", 32'(second_v), 32'd5);
    chk("t2_naddr", 32'(addrs.size() >= 3), 32'd1);
    if (addrs.size() >= 3) begin
      chk("t2_addr0", 32'(addrs[0]), 32'd0);
      chk("t2_addr1", 32'(addrs[1]), 32'd1);
      chk("t2_addr2", 32'(addrs[2]), 32'd2);
    end

    // Backpressure: outputs hold, no reads, fetch issued in handshake cycle.
    mem[0] = 8'd4; mem[1] = 8'd5;
    bus.dec_ready = 1'b0;
    do_reset();
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(bus.dec_valid), 32'd1);
      chk("t3_hold_op", 32'(bus.dec_op), 32'd4);
      chk("t3_hold_pc", 32'(bus.dec_pc), 32'd0);
      chk("t3_hold_mem_en", 32'(bus.mem_en), 32'd0);
      nxt();
    end
    bus.dec_ready = 1'b1;
    #1;
    chk("t3_hs_mem_en", 32'(bus.mem_en), 32'd1);
    chk("t3_hs_addr", 32'(bus.mem_addr), 32'd1);
    nxt();
    nxt();
    chk("t3_next_valid", 32'(bus.dec_valid), 32'd1);
    chk("t3_next_pc", 32'(bus.dec_pc), 32'd1);

    // Jump redirect flushes the following instruction.
    mem[8'h10] = 8'd6; mem[8'h11] = 8'h40; mem[8'h12] = 8'd4; mem[8'h40] = 8'd5;
    do_reset();
    redirect(8'h10);
    wait_valid(n);
    chk("t4_op", 32'(bus.dec_op), 32'd6);
    chk("t4_imm", 32'(bus.dec_imm), 32'h40);
    chk("t4_pc", 32'(bus.dec_pc), 32'h10);
    nxt();
    chk("t4_opc_valid", 32'(bus.dec_valid), 32'd0);
    redirect(8'h40);
    wait_valid(n);
    chk("t4_tgt_op", 32'(bus.dec_op), 32'd5);
    chk("t4_tgt_pc", 32'(bus.dec_pc), 32'h40);

    // Immediate wraps to address 0.
    mem[8'hFF] = 8'd1; mem[0] = 8'h07;
    redirect(8'hFF);
    nxt();
    chk("t5_imm_mem_en", 32'(bus.mem_en), 32'd1);
    chk("t5_imm_addr", 32'(bus.mem_addr), 32'd0);
    nxt();
    nxt();
    chk("t5_op", 32'(bus.dec_op), 32'd1);
    chk("t5_imm", 32'(bus.dec_imm), 32'h07);
    chk("t5_pc", 32'(bus.dec_pc), 32'hFF);
    chk("t5_next_addr", 32'(bus.mem_addr), 32'd1);

    // Illegal opcode: one byte long, sticky flag until reset.
    mem[8'h20] = 8'hC8; mem[8'h21] = 8'd4;
    redirect(8'h20);
    chk("t6_ill_before", 32'(illegal_seen), 32'd0);
    wait_valid(n);
    chk("t6_op", 32'(bus.dec_op), 32'd12);
    chk("t6_imm", 32'(bus.dec_imm), 32'd0);
    chk("t6_ill", 32'(illegal_seen), 32'd1);
    nxt();
    wait_valid(n);
    chk("t6_next_pc", 32'(bus.dec_pc), 32'h21);
    chk("t6_ill_sticky", 32'(illegal_seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_ill_reset", 32'(illegal_seen), 32'd0);
    chk("t6_valid_reset", 32'(bus.dec_valid), 32'd0);

    // Random program with random backpressure, halts and redirects.
    foreach (mem[i]) mem[i] = ($urandom_range(0, 19) == 0) ? 8'(8'hC0 + $urandom_range(0, 63))
                                                          : 8'($urandom_range(0, 12));
    do_reset();
    model_pc  = 8'h00;
    model_ill = 1'b0;
    nhs       = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.dec_ready      = ($urandom_range(0, 3) != 0);
      run                = ($urandom_range(0, 7) != 0);
      redir              = ($urandom_range(0, 24) == 0);
      bus.redirect_valid = redir;
      bus.redirect_addr  = 8'($urandom);
      #1;
      if (bus.dec_valid) begin
        nb = model_pc + 8'd1;
        chk("rnd_op", 32'(bus.dec_op), 32'(m_op(mem[model_pc])));
        chk("rnd_imm", 32'(bus.dec_imm), (m_len(mem[model_pc]) == 8'd2) ? 32'(mem[nb]) : 32'd0);
        chk("rnd_pc", 32'(bus.dec_pc), 32'(model_pc));
        if (m_op(mem[model_pc]) == 12) model_ill = 1'b1;
      end
      chk("rnd_illegal", 32'(illegal_seen), 32'(model_ill));
      if (redir) chk("rnd_redir_mem_en", 32'(bus.mem_en), 32'd0);
      if (bus.dec_valid && bus.dec_ready) begin
        model_pc = model_pc + m_len(mem[model_pc]);
        nhs++;
      end
      if (redir) model_pc = bus.redirect_addr;
      nxt();
    end
    bus.redirect_valid = 1'b0;
    chk("rnd_progress", 32'(nhs > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
